deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_pkg.sv | 15 +
 rtl/deserializer_shifter.sv | 32 +++
 rtl/deserializer.sv | 77 +++++++
 tb/tb_deserializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Provides the FILL/FULL state encoding and the word-counter width helper.
package deserializer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // Counter width for n words, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/deserializer_shifter.sv
// Word shifter: parallel load, or shift one word in at the top slice.
// Ports: clock, load/parallel_in, enable/serial_in, parallel_out.
module shifter #(
   parameter int count = 0,
   parameter int width = 0
) (
   input  logic                     clock,
   input  logic                     load,
   input  logic                     enable,
   input  logic [count*width-1:0]   parallel_in,
   input  logic [width-1:0]         serial_in,
   output logic [count*width-1:0]   parallel_out
);

   logic [count*width-1:0] shifted;

   // New word lands in the top slice; older words move down one.
   if (count == 1) begin : g_one
      assign shifted = serial_in;
   end else begin : g_many
      assign shifted = {serial_in, parallel_out[count*width-1:width]};
   end

   always_ff @(posedge clock) begin
      if (load) begin
         parallel_out <= parallel_in;
      end else if (enable) begin
         parallel_out <= shifted;
      end
   end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: gathers count words into one frame.
// Ports: clock, reset, clear, serial_in/valid/ready, parallel_out/valid/ready.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int count = 0,
   parameter int width = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [width-1:0]         serial_in,
   input  logic                     serial_valid,
   output logic                     serial_ready,
   output logic [count*width-1:0]   parallel_out,
   output logic                     parallel_valid,
   input  logic                     parallel_ready
);

   localparam int cw = cnt_width(count);
   localparam logic [cw-1:0] last = cw'(count - 1);

   state_t          state, state_next;
   logic [cw-1:0]   cnt, cnt_next, base;
   logic            accept;

   assign parallel_valid = (state == FULL);
   assign serial_ready   = !reset && (!parallel_valid || parallel_ready);
   assign accept         = serial_valid && serial_ready && !clear;

   shifter #(
      .count (count),
      .width (width)
   ) u_shifter (
      .clock        (clock),
      .load         (1'b0),
      .enable       (accept),
      .parallel_in  ('0),
      .serial_in    (serial_in),
      .parallel_out (parallel_out)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // An accept while FULL consumes the frame and starts the next
   // one at word 0, so it is treated like an accept from an empty
   // counter.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      base       = (state == FULL) ? '0 : cnt;
      if (clear) begin
         state_next = FILL;
         cnt_next   = '0;
      end else if (accept) begin
         if (base == last) begin
            state_next = FULL;
            cnt_next   = '0;
         end else begin
            state_next = FILL;
            cnt_next   = base + 1'b1;
         end
      end else if (state == FULL && parallel_ready) begin
         state_next = FILL;
         cnt_next   = '0;
      end
   end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (count=4 and count=1 instances).
// Queue-based frame model plus directed and random stimulus.
module tb_deserializer;

   logic        clock;
   logic        reset, clear, serial_valid, parallel_ready;
   logic [7:0]  serial_in;
   logic        serial_ready, parallel_valid;
   logic [31:0] parallel_out;

   logic        reset_1, clear_1, serial_valid_1, parallel_ready_1;
   logic [7:0]  serial_in_1;
   logic        serial_ready_1, parallel_valid_1;
   logic [7:0]  parallel_out_1;

   int checks = 0;
   int errors = 0;

   // model for count=4
   logic [7:0]  q[$];
   logic        m_valid = 1'b0;
   logic [31:0] m_frame = '0;

   // model for count=1
   logic        m1_valid = 1'b0;
   logic [7:0]  m1_frame = '0;

   deserializer #(.count(4), .width(8)) dut4 (
      .clock          (clock),
      .reset          (reset),
      .clear          (clear),
      .serial_in      (serial_in),
      .serial_valid   (serial_valid),
      .serial_ready   (serial_ready),
      .parallel_out   (parallel_out),
      .parallel_valid (parallel_valid),
      .parallel_ready (parallel_ready)
   );

   deserializer #(.count(1), .width(8)) dut1 (
      .clock          (clock),
      .reset          (reset_1),
      .clear          (clear_1),
      .serial_in      (serial_in_1),
      .serial_valid   (serial_valid_1),
      .serial_ready   (serial_ready_1),
      .parallel_out   (parallel_out_1),
      .parallel_valid (parallel_valid_1),
      .parallel_ready (parallel_ready_1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step4(input logic rst, input logic clr, input logic sv,
                        input logic [7:0] w, input logic pr);
      logic rdy, acc;
      @(negedge clock);
      reset = rst; clear = clr; serial_valid = sv;
      serial_in = w; parallel_ready = pr;
      rdy = !rst && (!m_valid || pr);
      #1 check("serial_ready", 32'(serial_ready), 32'(rdy));
      @(posedge clock);
      if (rst || clr) begin
         q.delete();
         m_valid = 1'b0;
      end else begin
         acc = sv && rdy;
         if (m_valid && pr) m_valid = 1'b0;
         if (acc) begin
            q.push_back(w);
            if (q.size() == 4) begin
               for (int i = 0; i < 4; i++) m_frame[i*8 +: 8] = q[i];
               m_valid = 1'b1;
               q.delete();
            end
         end
      end
      #1;
      check("parallel_valid", 32'(parallel_valid), 32'(m_valid));
      if (m_valid) check("parallel_out", parallel_out, m_frame);
   endtask

   task automatic step1(input logic rst, input logic sv,
                        input logic [7:0] w, input logic pr);
      logic rdy;
      @(negedge clock);
      reset_1 = rst; clear_1 = 1'b0; serial_valid_1 = sv;
      serial_in_1 = w; parallel_ready_1 = pr;
      rdy = !rst && (!m1_valid || pr);
      #1 check("c1_serial_ready", 32'(serial_ready_1), 32'(rdy));
      @(posedge clock);
      if (rst) begin
         m1_valid = 1'b0;
      end else begin
         if (m1_valid && pr) m1_valid = 1'b0;
         if (sv && rdy) begin
            m1_valid = 1'b1;
            m1_frame = w;
         end
      end
      #1;
      check("c1_parallel_valid", 32'(parallel_valid_1), 32'(m1_valid));
      if (m1_valid) check("c1_parallel_out", 32'(parallel_out_1), 32'(m1_frame));
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; serial_valid = 1'b0;
      serial_in = '0; parallel_ready = 1'b0;
      reset_1 = 1'b1; clear_1 = 1'b0; serial_valid_1 = 1'b0;
      serial_in_1 = '0; parallel_ready_1 = 1'b0;

      step4(1, 0, 1, 8'h99, 1);
      step4(1, 0, 0, 8'h00, 0);
      check("reset_valid", 32'(parallel_valid), 32'd0);

      // back-to-back feed
      step4(0, 0, 1, 8'h11, 1);
      step4(0, 0, 1, 8'h22, 1);
      step4(0, 0, 1, 8'h33, 1);
      check("b2b_not_yet", 32'(parallel_valid), 32'd0);
      step4(0, 0, 1, 8'h44, 1);
      check("b2b_valid", 32'(parallel_valid), 32'd1);
      check("b2b_frame", parallel_out, 32'h44332211);

      // backpressure
      for (int i = 0; i < 5; i++) begin
         step4(0, 0, 1, 8'h55, 0);
         check("bp_ready", 32'(serial_ready), 32'd0);
         check("bp_hold", parallel_out, 32'h44332211);
      end
      step4(0, 0, 1, 8'h55, 1);
      check("bp_release_valid", 32'(parallel_valid), 32'd0);
      check("bp_partial", 32'(q.size()), 32'd1);

      // streaming, discard the 0x55 partial first
      step4(0, 1, 0, 8'h00, 1);
      for (int k = 1; k <= 12; k++) begin
         step4(0, 0, 1, 8'(k), 1);
         check("stream_pulse", 32'(parallel_valid), 32'(k % 4 == 0));
         if (k == 4)  check("stream_f0", parallel_out, 32'h04030201);
         if (k == 8)  check("stream_f1", parallel_out, 32'h08070605);
         if (k == 12) check("stream_f2", parallel_out, 32'h0C0B0A09);
      end
      step4(0, 0, 0, 8'h00, 1);

      // clear mid-frame
      step4(0, 0, 1, 8'hAA, 1);
      step4(0, 0, 1, 8'hBB, 1);
      step4(0, 1, 1, 8'hCC, 1);
      for (int k = 1; k <= 4; k++) step4(0, 0, 1, 8'(k), 1);
      check("clear_valid", 32'(parallel_valid), 32'd1);
      check("clear_frame", parallel_out, 32'h04030201);
      step4(0, 0, 0, 8'h00, 1);

      // reset mid-frame
      step4(0, 0, 1, 8'hAA, 1);
      step4(0, 0, 1, 8'hBB, 1);
      step4(0, 0, 1, 8'hCC, 1);
      step4(1, 0, 1, 8'hDD, 1);
      check("rst_mid_valid", 32'(parallel_valid), 32'd0);
      for (int k = 1; k <= 4; k++) step4(0, 0, 1, 8'(k), 1);
      check("rst_frame", parallel_out, 32'h04030201);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step4($urandom_range(0, 63) == 0,
               $urandom_range(0, 31) == 0,
               $urandom_range(0, 3) != 0,
               8'($urandom),
               $urandom_range(0, 2) != 0);
      end

      // count=1 instance
      step1(1, 0, 8'h00, 0);
      check("c1_reset_valid", 32'(parallel_valid_1), 32'd0);
      step1(0, 1, 8'h10, 1);
      check("c1_f10", 32'(parallel_out_1), 32'h10);
      step1(0, 1, 8'h20, 1);
      check("c1_v20", 32'(parallel_valid_1), 32'd1);
      check("c1_f20", 32'(parallel_out_1), 32'h20);
      step1(0, 1, 8'h30, 1);
      check("c1_v30", 32'(parallel_valid_1), 32'd1);
      check("c1_f30", 32'(parallel_out_1), 32'h30);
      for (int i = 0; i < 200; i++) begin
         step1($urandom_range(0, 63) == 0,
               $urandom_range(0, 3) != 0,
               8'($urandom),
               $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
